// File: rtl/aes_dec_arbiter.sv
// Round-robin front end sharing one inverse-AES core between two requesters; AES_DEC_ARB_TIMEOUT_EN adds a watchdog.
// Latency: gnt in the cycle after req is sampled in IDLE; done in the cycle after core_busy falls (or the watchdog fires).
// Backpressure: requesters hold req until gnt; one job in flight, other requests wait until the block returns to IDLE.
module aes_dec_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [127:0] key0,
  input  logic [127:0] key1,
  input  logic [127:0] ct0,
  input  logic [127:0] ct1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [127:0] pt,
  output logic         err,
  output logic         core_we,
  output logic [127:0] core_secret,
  output logic [127:0] core_cipher,
  input  logic [127:0] core_plaintext,
  input  logic         core_busy
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RUN, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic         owner;
  logic         last;
  logic         pick;
  logic         tmo;
  logic         abort;
  logic [127:0] key_q;
  logic [127:0] ct_q;
  logic [127:0] pt_q;

  // On a tie the requester that was not served last wins.
  assign pick = req1 & (~req0 | ~last);

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      IDLE:   if (req0 | req1) state_nxt = LAUNCH;
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (tmo) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end else if (core_busy) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!core_busy) begin
          state_nxt = DONE;
        end else if (tmo) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      key_q <= '0;
      ct_q  <= '0;
      pt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req0 | req1)) begin
        owner <= pick;
        last  <= pick;
        key_q <= pick ? key1 : key0;
        ct_q  <= pick ? ct1 : ct0;
      end
      if (state == RUN && !core_busy) begin
        pt_q <= core_plaintext;
      end else if (abort) begin
        pt_q <= '0;
      end
    end
  end

`ifdef AES_DEC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // Counts cycles spent waiting on the core; err_q remembers why DONE was entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        cnt <= '0;
      end else if (state == WAIT || state == RUN) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state_nxt == DONE) begin
        err_q <= abort;
      end
    end
  end

  assign tmo = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign err = (state == DONE) & err_q;
`else
  // No watchdog in this build: constant-false for any legal TIMEOUT_CYCLES.
  assign tmo = (TIMEOUT_CYCLES < 0);
  assign err = 1'b0;
`endif

  assign gnt0        = (state == LAUNCH) & ~owner;
  assign gnt1        = (state == LAUNCH) & owner;
  assign done0       = (state == DONE) & ~owner;
  assign done1       = (state == DONE) & owner;
  assign core_we     = (state == LAUNCH);
  assign core_secret = key_q;
  assign core_cipher = ct_q;
  assign pt          = pt_q;

endmodule
